aes_spi_master: RTL
===================

# aes_spi_master

Serial front end that drives the AES SPI slave. It accepts a 128-bit block and an Nk-word key in parallel from the host side. It shifts both out LSB-first on SIMO with CSS low and mode = encrypt, then waits a fixed compute interval. It then switches mode to decrypt/readback, collects 128 result bits from SOMI into a parallel register, and pulses done.

## Interface
- Nk, 4, key length in 32-bit words (4, 6 or 8); key is Nk*32 bits.
- WAIT_CYCLES, 2, idle cycles between last key bit and start of readback (AES settle time); legal range 1..255.
- RD_LAT, 1, cycles from mode rising until SOMI carries result bit 0; legal range 0..3.
- clk  in  1  system clock, shared with the slave; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a transaction; sampled only in IDLE.
- msg_in  in  128  data block, bit 0 sent first.
- key_in  in  Nk*32  key, bit 0 sent first.
- SOMI  in  1  serial result from slave.
- SIMO  out  1  serial data to slave.
- CSS  out  1  chip select, active low.
- mode  out  1  0 = load (encr), 1 = readback (decr).
- result  out  128  collected result; bit 0 is the first bit received.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when result is valid.

## Operation
- Reset values: CSS=1, SIMO=0, mode=0, busy=0, done=0, result=0, state=IDLE, bit counter=0.
- States: IDLE -> SEND_MSG -> SEND_KEY -> WAIT -> READ -> DONE -> IDLE.
- IDLE: on start=1, latch msg_in/key_in into internal shift registers and go to SEND_MSG. Later changes on msg_in/key_in have no effect.
- SEND_MSG: CSS=0, mode=0. SIMO = current LSB of the message shift register; shift right one per cycle. Lasts exactly 128 cycles.
- SEND_KEY: CSS=0, mode=0. Shifts the key out the same way. Lasts exactly Nk*32 cycles.
- WAIT: CSS=0, mode=0, SIMO=0. Lasts WAIT_CYCLES cycles.
- READ: CSS=0, mode=1. After RD_LAT cycles, sample SOMI on each of 128 consecutive cycles: result <= {SOMI, result[127:1]}. Lasts RD_LAT+128 cycles.
- DONE: CSS=1, mode=0, done=1 for one cycle, busy=0. Result holds until the next transaction's first READ sample.
- Bit counter: 9 bits, reset to 0 on each state entry. The terminal count per state is 127, Nk*32-1, WAIT_CYCLES-1, or RD_LAT+127.
- start while busy is ignored (no queueing). start held high in DONE is not seen. start held high across the return to IDLE launches a new transaction the cycle after IDLE is re-entered.
- rst mid-transaction: the next cycle shows all reset values. The partial result is discarded (result=0) and no done pulse is produced.

## Timing
- Cycle 0: start=1 sampled in IDLE.
- Cycle 1: CSS falls, SIMO=msg_in[0], busy=1.
- Cycle k (1..128): SIMO=msg_in[k-1].
- Cycle 128+m (m=1..Nk*32): SIMO=key_in[m-1].
- Let T = 128 + Nk*32 + WAIT_CYCLES.
- Cycle T+1: mode rises.
- Cycles T+1+RD_LAT .. T+RD_LAT+128: SOMI is sampled, bit 0 first.
- Cycle T+RD_LAT+129: done=1, CSS=1.
- Total latency from start to done: 257 + Nk*32 + WAIT_CYCLES + RD_LAT cycles. With defaults (Nk=4) this is 388 cycles.
- SIMO, CSS and mode are registered outputs; no combinational path from any input to any output.

## Test plan
- Reset check: assert rst 3 cycles with random inputs -> CSS=1, SIMO=0, mode=0, busy=0, done=0, result=0.
- Serial load: Nk=4, msg_in=00112233445566778899aabbccddeeff, key_in=000102030405060708090a0b0c0d0e0f, start pulse. Capture SIMO during CSS=0 && mode=0 -> the first 128 bits reassemble msg_in LSB-first, the next 128 bits reassemble key_in, then WAIT_CYCLES zeros. done occurs exactly 388 cycles after start.
- End-to-end: connect the AES slave model with ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a on its readback -> result equals that value and done pulses once.
- Readback ordering: the SOMI model drives a walking pattern 0x1 (bit 0 high only), RD_LAT=0 and RD_LAT=2 -> result=00000000000000000000000000000001 in both cases.
- Busy/start: pulse start at cycle 50 and again in DONE -> neither launches a transaction. Then hold start high continuously -> a second transaction begins the cycle after IDLE is re-entered.
- Reset mid-op: assert rst during the READ state at sample 60 -> the next cycle shows reset values, no done pulse. A subsequent start completes with the correct result.

Source files
------------

// File: rtl/aes_spi_master.sv
// Serial front end for the AES SPI slave: shifts a block and key out on SIMO,
// waits for the core to settle, then reads 128 result bits back from SOMI.
module aes_spi_master #(
  parameter int unsigned Nk          = 4,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned RD_LAT      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [127:0]     msg_in,
  input  logic [Nk*32-1:0] key_in,
  input  logic             SOMI,
  output logic             SIMO,
  output logic             CSS,
  output logic             mode,
  output logic [127:0]     result,
  output logic             busy,
  output logic             done
);

  localparam int unsigned KeyBits = Nk * 32;

  localparam logic [8:0] MsgLast   = 9'd127;
  localparam logic [8:0] KeyLast   = 9'(KeyBits - 1);
  localparam logic [8:0] WaitLast  = 9'(WAIT_CYCLES - 1);
  localparam logic [8:0] ReadFirst = 9'(RD_LAT);
  localparam logic [8:0] ReadLast  = 9'(RD_LAT + 127);

  typedef enum logic [2:0] {
    StIdle,
    StSendMsg,
    StSendKey,
    StWait,
    StRead,
    StDone
  } state_e;

  state_e               state_q;
  logic [8:0]           cnt_q;
  logic [127:0]         msg_sr_q;
  logic [KeyBits-1:0]   key_sr_q;
  logic [8:0]           rd_idx;

  // Wraps high while still inside the read latency, so only the 128 data cycles sample.
  assign rd_idx = cnt_q - ReadFirst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      msg_sr_q <= '0;
      key_sr_q <= '0;
      SIMO     <= 1'b0;
      CSS      <= 1'b1;
      mode     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StSendMsg;
            cnt_q    <= '0;
            msg_sr_q <= {1'b0, msg_in[127:1]};
            key_sr_q <= key_in;
            SIMO     <= msg_in[0];
            CSS      <= 1'b0;
            busy     <= 1'b1;
          end
        end
        StSendMsg: begin
          if (cnt_q == MsgLast) begin
            state_q  <= StSendKey;
            cnt_q    <= '0;
            SIMO     <= key_sr_q[0];
            key_sr_q <= key_sr_q >> 1;
          end else begin
            cnt_q    <= cnt_q + 9'd1;
            SIMO     <= msg_sr_q[0];
            msg_sr_q <= msg_sr_q >> 1;
          end
        end
        StSendKey: begin
          if (cnt_q == KeyLast) begin
            state_q <= StWait;
            cnt_q   <= '0;
            SIMO    <= 1'b0;
          end else begin
            cnt_q    <= cnt_q + 9'd1;
            SIMO     <= key_sr_q[0];
            key_sr_q <= key_sr_q >> 1;
          end
        end
        StWait: begin
          if (cnt_q == WaitLast) begin
            state_q <= StRead;
            cnt_q   <= '0;
            mode    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 9'd1;
          end
        end
        StRead: begin
          if (rd_idx < 9'd128) begin
            result <= {SOMI, result[127:1]};
          end
          if (cnt_q == ReadLast) begin
            state_q <= StDone;
            cnt_q   <= '0;
            CSS     <= 1'b1;
            mode    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 9'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule
